// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared encodings for the RV32I pipeline: result-select codes used by the
// writeback mux and the load funct3 codes used by the load extender.
// No ports (package).
package riscv_pkg;

    // Result select encodings; 2'b11 is reserved and behaves like RES_ALU
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    // Load width/sign codes (funct3 of the load opcode)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Register x0 is hardwired to zero, so a write to it must never be issued
    function automatic logic is_x0(input logic [4:0] rd);
        return (rd == 5'd0);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if
// Memory-to-writeback bundle plus the register-file write port it produces.
//   M-stage side : ValidM, RegWriteM, ResultSrcM, Funct3M, RdM,
//                  ALUResultM, ReadDataM, PCPlus4M
//   W-stage side : ResultW, RdW, RegWriteW, ValidW
// Modports:
//   master - memory stage / pipeline driver (drives M, observes W)
//   slave  - writeback stage (consumes M, drives W)
interface writeback_stage_if #(
    parameter int XLEN = 32
);
    logic            ValidM;
    logic            RegWriteM;
    logic [1:0]      ResultSrcM;
    logic [2:0]      Funct3M;
    logic [4:0]      RdM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] ReadDataM;
    logic [XLEN-1:0] PCPlus4M;

    logic [XLEN-1:0] ResultW;
    logic [4:0]      RdW;
    logic            RegWriteW;
    logic            ValidW;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALUResultM, ReadDataM, PCPlus4M,
        input  ResultW, RdW, RegWriteW, ValidW
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALUResultM, ReadDataM, PCPlus4M,
        output ResultW, RdW, RegWriteW, ValidW
    );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// load_extend
// Picks the addressed byte/halfword out of an aligned data-memory word and
// sign- or zero-extends it according to the load funct3.
// Ports:
//   funct3 in  3   load width/sign code
//   off    in  2   byte offset within the word (address bits [1:0])
//   word   in  32  raw aligned memory word
//   ext    out 32  extended load value
module load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: halfwords only care about off[1]; a misaligned lh
    // quietly uses the containing halfword since misalignment is not checked.
    always_comb begin
        byte_sel = 8'h00;
        case (off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    // Extension; lw and every unlisted code pass the word through untouched
    always_comb begin
        ext = word;
        case (funct3)
            F3_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ext = {24'h000000, byte_sel};
            F3_LH:   ext = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ext = {16'h0000, half_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
// M/W pipeline register plus architectural result selection for the 5-stage
// RV32I core. Drives the register-file write port and the W forwarding value.
// Ports:
//   clk       in   core clock, rising edge
//   reset_n   in   synchronous reset, ACTIVE HIGH despite the name
//   StallW    in   hold the W register
//   FlushW    in   load a bubble (wins over StallW)
//   wb        slave modport of writeback_stage_if (M bundle in, W port out)
//   InstRetW  out  64-bit retired-instruction count (WB_RETIRE_CNT_EN only)
// Configuration macro: WB_RETIRE_CNT_EN adds the retire counter and InstRetW.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 StallW,
    input  logic                 FlushW,
    writeback_stage_if.slave     wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]          InstRetW
`endif
);

    logic            valid_w;
    logic            reg_write_w_q;
    logic [1:0]      result_src_w;
    logic [2:0]      funct3_w;
    logic [4:0]      rd_w;
    logic [XLEN-1:0] alu_result_w;
    logic [XLEN-1:0] read_data_w;
    logic [XLEN-1:0] pc_plus4_w;
    logic [31:0]     load_ext_w;
    logic [XLEN-1:0] result_w;

    // W register. Reset and flush both produce an all-zero bubble, which also
    // makes ResultW read as zero (ALU select of a zero ALU result).
    always_ff @(posedge clk) begin
        if (reset_n || FlushW) begin
            valid_w       <= 1'b0;
            reg_write_w_q <= 1'b0;
            result_src_w  <= RES_ALU;
            funct3_w      <= 3'b000;
            rd_w          <= 5'd0;
            alu_result_w  <= '0;
            read_data_w   <= '0;
            pc_plus4_w    <= '0;
        end else if (!StallW) begin
            valid_w       <= wb.ValidM;
            reg_write_w_q <= wb.RegWriteM;
            result_src_w  <= wb.ResultSrcM;
            funct3_w      <= wb.Funct3M;
            rd_w          <= wb.RdM;
            alu_result_w  <= wb.ALUResultM;
            read_data_w   <= wb.ReadDataM;
            pc_plus4_w    <= wb.PCPlus4M;
        end
    end

    load_extend u_load_extend (
        .funct3 (funct3_w),
        .off    (alu_result_w[1:0]),
        .word   (read_data_w),
        .ext    (load_ext_w)
    );

    // Result mux; the reserved select code falls back to the ALU result
    always_comb begin
        result_w = alu_result_w;
        case (result_src_w)
            RES_LOAD: result_w = load_ext_w;
            RES_PC4:  result_w = pc_plus4_w;
            default:  result_w = alu_result_w;
        endcase
    end

    assign wb.ResultW   = result_w;
    assign wb.RdW       = rd_w;
    assign wb.ValidW    = valid_w;
    assign wb.RegWriteW = reg_write_w_q & valid_w & ~is_x0(rd_w);

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] inst_ret_q;

    // Retire counter: the instruction in W retires whenever it leaves W
    // without being held, so a flush behind it does not cancel the count.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            inst_ret_q <= 64'd0;
        end else if (valid_w && !StallW) begin
            inst_ret_q <= inst_ret_q + 64'd1;
        end
    end

    assign InstRetW = inst_ret_q;
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Memory/writeback pipeline register plus result selection for the 5-stage RV32I core. Captures the memory-stage bundle each cycle, selects the architectural result (ALU result, extended load data, or PC+4), and drives the register-file write port (ResultW, RdW, WE3) consumed by the decode stage. This is the writer side of the decode stage's register-file interface, and the source of the W-stage forwarding value.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  synchronous, active-high reset; name kept for codebase consistency.
- StallW  in  1  hold the W register contents.
- FlushW  in  1  load a bubble into W.
- ValidM  in  1  memory-stage slot holds a real instruction.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- Funct3M  in  3  load width/sign code.
- RdM  in  5  destination register.
- ALUResultM  in  32  ALU result or load address.
- ReadDataM  in  32  raw aligned data-memory word.
- PCPlus4M  in  32  link value.
- ResultW  out  32  write data to register file and forwarding path.
- RdW  out  5  write address.
- RegWriteW  out  1  write enable; connects to the register file's WE3.
- ValidW  out  1  W slot holds a real instruction.
- InstRetW  out  64  retired-instruction count (only with WB_RETIRE_CNT_EN).

## Operation
- The W register holds ValidW, RegWriteW_q, ResultSrcW, Funct3W, RdW, ALUResultW, ReadDataW, and PCPlus4W.
- Priority at each rising edge, highest first:
  - reset_n=1: clear all W fields to 0.
  - FlushW=1: clear all fields (bubble); flush wins over stall.
  - StallW=1: hold all fields.
  - Otherwise: capture all M-stage inputs.
- RegWriteW = RegWriteW_q & ValidW & (RdW != 0). A write to x0 is never issued.
- ResultW is combinational from the W fields:
  - ResultSrcW 00 or 11: ALUResultW.
  - ResultSrcW 01: LoadExtW.
  - ResultSrcW 10: PCPlus4W.
- Load extension uses byte offset off = ALUResultW[1:0]:
  - 000 lb: sign-extend byte ReadDataW[8*off+7 : 8*off].
  - 100 lbu: zero-extend the same byte.
  - 001 lh: sign-extend halfword at offset off[1] (off[0] ignored).
  - 101 lhu: zero-extend the same halfword.
  - 010 lw and all other codes: ReadDataW unchanged.
- Misalignment is not detected here.

## Timing
- Latency: 1 cycle from the M inputs to the W fields. ResultW, RdW, and RegWriteW are valid in the cycle after capture, with no additional register.
- During a stall the outputs stay constant. The register file may rewrite the same value, which is harmless.
- Reset values:
  - ResultW=0, RdW=0, RegWriteW=0, ValidW=0, InstRetW=0.
  - ResultW is 0 because ALUResultW=0 and ResultSrcW=00.
- Reset asserted mid-stall or mid-flush: reset wins in the same edge.
- FlushW and StallW together: a bubble is loaded.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - 64-bit InstRetW counter is present.
  - It increments by 1 on each rising edge where ValidW=1, StallW=0, and reset_n=0.
  - It wraps from 2^64−1 to 0.
  - A flush does not block retirement of the instruction currently in W.
- Not defined: the InstRetW port and the counter are absent.

## Structure
- Shared package riscv_pkg holds:
  - ResultSrc encodings: RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- One combinational sub-module, load_extend, with inputs funct3, off[1:0], word[31:0] and output ext[31:0]. The top contains the register, the result mux, the x0 gating, and the counter.

## Test plan
- Reset: hold reset_n=1 for 2 cycles with random M inputs → all outputs 0; RegWriteW=0.
- ALU writeback: ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALUResultM=0x0000_1234 → next cycle ResultW=0x1234, RdW=5, RegWriteW=1.
- Loads with ReadDataM=0x80FF_7F01:
  - lb at off=1 → 0x0000_007F.
  - lb at off=2 → 0xFFFF_FFFF.
  - lbu at off=3 → 0x0000_0080.
  - lh at off=2 → 0xFFFF_80FF.
  - lhu at off=0 → 0x0000_7F01.
  - lw → 0x80FF_7F01.
- Link and x0: ResultSrcM=10, PCPlus4M=0x104, RdM=1 → ResultW=0x104, RegWriteW=1. Repeat with RdM=0 → RegWriteW=0.
- Stall/flush:
  - StallW=1 for 3 cycles while M changes → W outputs unchanged.
  - StallW=1 with FlushW=1 → ValidW=0, RegWriteW=0 next cycle.
- Counter (WB_RETIRE_CNT_EN): 10 valid instructions, 2 stall cycles, and 1 bubble → InstRetW=10. Preload the counter near 2^64−1 via a bench force → it wraps to 0.
